// File: rtl/uart_rx_cfg_pkg.sv
// Shared constants and state encoding for the configurable UART receiver.
package uart_rx_cfg_pkg;

    localparam int UART_PARITY_NONE = 0;
    localparam int UART_PARITY_ODD  = 1;
    localparam int UART_PARITY_EVEN = 2;

    localparam logic UART_START_BIT = 1'b0;
    localparam logic UART_STOP_BIT  = 1'b1;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    // Expected parity bit given the XOR-reduction of the data bits.
    function automatic logic exp_parity(input int mode, input logic data_xor);
        return (mode == UART_PARITY_EVEN) ? data_xor : ~data_xor;
    endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Receive-side pop interface: FIFO head plus status toward the bus block.
interface uart_rx_cfg_if #(
    parameter int DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_parity_err;
    logic                 rx_frame_err;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 rx_busy;
    logic                 rx_overrun;

    modport master (
        output rx_data, rx_parity_err, rx_frame_err, rx_valid, rx_busy, rx_overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_parity_err, rx_frame_err, rx_valid, rx_busy, rx_overrun,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO with registered head data and pointer-plus-wrap-bit occupancy.
module uart_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             wr_en, rd_en, wr_is_head, head_upd;

    assign empty_o  = (wr_ptr_q == rd_ptr_q);
    assign full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign wr_en    = push_i && (!full_o || pop_i);
    assign rd_en    = pop_i && !empty_o;
    assign rd_ptr_d = rd_ptr_q + (AW+1)'(rd_en);
    // The written slot becomes the head only when the FIFO is otherwise empty.
    assign wr_is_head = wr_en && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0]);
    assign head_upd   = rd_en || wr_is_head;
    assign rdata_d    = wr_is_head ? wdata_i : mem_q[rd_ptr_d[AW-1:0]];
    assign rdata_o    = rdata_q;

    // Storage array, no reset needed: occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

    // Pointers and registered head; head only moves on a pop or a write into an empty FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rdata_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            rd_ptr_q <= rd_ptr_d;
            if (head_upd) rdata_q <= rdata_d;
        end
    end
endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: synchroniser, mid-bit sampling FSM and receive FIFO.
module uart_rx_cfg
    import uart_rx_cfg_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int DIV_RATE   = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx,
    uart_rx_cfg_if.master bus
);
    localparam int                DIVW     = $clog2(DIV_RATE);
    localparam logic [DIVW-1:0]   HALF_LD  = DIVW'(DIV_RATE/2 - 1);
    localparam logic [DIVW-1:0]   FULL_LD  = DIVW'(DIV_RATE - 1);
    localparam logic [2:0]        LAST_BIT = 3'(DATA_BITS - 1);

    rx_state_e              state_q;
    logic                   rx_meta_q, rxs_q;
    logic [DIVW-1:0]        div_cnt_q;
    logic [2:0]             bit_cnt_q;
    logic [DATA_BITS-1:0]   shreg_q;
    logic                   perr_q, ferr_q, stop_cnt_q, armed_q, overrun_q;

    logic                   sample, last_stop, push, pop, fifo_empty, fifo_full;
    logic [DATA_BITS+1:0]   push_data, head;

    assign sample    = (div_cnt_q == '0);
    assign last_stop = (STOP_BITS == 1) || stop_cnt_q;
    assign push      = (state_q == RX_STOP) && sample && last_stop;
    assign push_data = {ferr_q | (rxs_q != UART_STOP_BIT), perr_q, shreg_q};
    assign pop       = bus.rx_valid && bus.rx_ready;

    // Two-flop synchroniser for the asynchronous line; resets to the idle level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rxs_q     <= rx_meta_q;
        end
    end

    // Receive FSM; armed_q blocks re-triggering on a held-low (break) line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RX_IDLE;
            div_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            stop_cnt_q <= 1'b0;
            armed_q    <= 1'b1;
        end else begin
            if (rxs_q) armed_q <= 1'b1;
            if (state_q != RX_IDLE) div_cnt_q <= sample ? FULL_LD : div_cnt_q - DIVW'(1);
            case (state_q)
                RX_IDLE: begin
                    if (!rxs_q && armed_q) begin
                        state_q   <= RX_START;
                        div_cnt_q <= HALF_LD;
                    end
                end
                RX_START: begin
                    if (sample) state_q <= (rxs_q == UART_START_BIT) ? RX_DATA : RX_IDLE;
                end
                RX_DATA: begin
                    if (sample) begin
                        shreg_q <= {rxs_q, shreg_q[DATA_BITS-1:1]};
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_q <= '0;
                            state_q   <= (PARITY != UART_PARITY_NONE) ? RX_PARITY : RX_STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end
                end
                RX_PARITY: begin
                    if (sample) begin
                        if (rxs_q != exp_parity(PARITY, ^shreg_q)) perr_q <= 1'b1;
                        state_q <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (sample) begin
                        if (last_stop) begin
                            state_q    <= RX_IDLE;
                            perr_q     <= 1'b0;
                            ferr_q     <= 1'b0;
                            stop_cnt_q <= 1'b0;
                            if (!rxs_q) armed_q <= 1'b0;
                        end else begin
                            if (rxs_q != UART_STOP_BIT) ferr_q <= 1'b1;
                            stop_cnt_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

    // One-cycle overrun pulse when a finished frame finds the FIFO full with no pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) overrun_q <= 1'b0;
        else     overrun_q <= push && fifo_full && !pop;
    end

    uart_rx_fifo #(
        .WIDTH (DATA_BITS + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (push_data),
        .pop_i   (pop),
        .rdata_o (head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign bus.rx_data       = head[DATA_BITS-1:0];
    assign bus.rx_parity_err = head[DATA_BITS];
    assign bus.rx_frame_err  = head[DATA_BITS+1];
    assign bus.rx_valid      = !fifo_empty;
    assign bus.rx_busy       = (state_q != RX_IDLE);
    assign bus.rx_overrun    = overrun_q;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench: A = 8N1 depth 4, B = 7E2 depth 4, C = 8N1 depth 2, all at 16 clocks/bit.
module tb_uart_rx_cfg;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;
    int   checks = 0, failures = 0, cyc = 0;
    int   rise_a = -1, ovr_a = 0, ovr_c = 0, t0 = 0, o0 = 0;
    logic prev_va = 1'b0, busy_seen_a = 1'b0, valid_seen_a = 1'b0;
    logic [9:0] q_a[$], q_b[$], q_c[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_cfg_if #(.DATA_BITS(8)) ifa ();
    uart_rx_cfg_if #(.DATA_BITS(7)) ifb ();
    uart_rx_cfg_if #(.DATA_BITS(8)) ifc ();

    uart_rx_cfg #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DIV_RATE(16), .FIFO_DEPTH(4))
        dut_a (.clk(clk), .rst(rst), .rx(rx_a), .bus(ifa));
    uart_rx_cfg #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .DIV_RATE(16), .FIFO_DEPTH(4))
        dut_b (.clk(clk), .rst(rst), .rx(rx_b), .bus(ifb));
    uart_rx_cfg #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DIV_RATE(16), .FIFO_DEPTH(2))
        dut_c (.clk(clk), .rst(rst), .rx(rx_c), .bus(ifc));

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    task automatic unexpected(input string nm, input logic [9:0] got);
        checks++;
        failures++;
        $display("FAIL %s popped 0x%0h with nothing expected", nm, got);
    endtask

    // Monitors: compare every accepted pop against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && ifa.rx_valid && ifa.rx_ready) begin
            if (q_a.size() == 0) unexpected("pop_a", {ifa.rx_frame_err, ifa.rx_parity_err, ifa.rx_data});
            else check("pop_a", {ifa.rx_frame_err, ifa.rx_parity_err, ifa.rx_data}, q_a.pop_front());
        end
        if (!rst && ifb.rx_valid && ifb.rx_ready) begin
            if (q_b.size() == 0) unexpected("pop_b", {ifb.rx_frame_err, ifb.rx_parity_err, 1'b0, ifb.rx_data});
            else check("pop_b", {ifb.rx_frame_err, ifb.rx_parity_err, 1'b0, ifb.rx_data}, q_b.pop_front());
        end
        if (!rst && ifc.rx_valid && ifc.rx_ready) begin
            if (q_c.size() == 0) unexpected("pop_c", {ifc.rx_frame_err, ifc.rx_parity_err, ifc.rx_data});
            else check("pop_c", {ifc.rx_frame_err, ifc.rx_parity_err, ifc.rx_data}, q_c.pop_front());
        end
        if (ifa.rx_valid && !prev_va) rise_a = cyc;
        prev_va = ifa.rx_valid;
        if (ifa.rx_busy)    busy_seen_a = 1'b1;
        if (ifa.rx_valid)   valid_seen_a = 1'b1;
        if (ifa.rx_overrun) ovr_a++;
        if (ifc.rx_overrun) ovr_c++;
    end

    task automatic drive(input int ln, input logic v);
        case (ln)
            0:       rx_a = v;
            1:       rx_b = v;
            default: rx_c = v;
        endcase
    endtask

    task automatic hold_bit(input int ln, input logic v);
        drive(ln, v);
        repeat (16) @(posedge clk);
        #1;
    endtask

    // stops[0] is the first stop bit, stops[1] the second.
    task automatic send_frame(input int ln, input logic [7:0] d, input int nbits, input int par,
                              input logic flip, input logic [1:0] stops, input int nstop,
                              output int start_cyc);
        logic p;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        hold_bit(ln, 1'b0);
        p = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            hold_bit(ln, d[i]);
            p ^= d[i];
        end
        if (par != 0) begin
            if (par == 1) p = ~p;
            if (flip) p = ~p;
            hold_bit(ln, p);
        end
        for (int s = 0; s < nstop; s++) hold_bit(ln, stops[s]);
        drive(ln, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        ifa.rx_ready = 1'b0;
        ifb.rx_ready = 1'b0;
        ifc.rx_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid_a", ifa.rx_valid, 0);
        check("rst_data_a", ifa.rx_data, 0);
        check("rst_perr_a", ifa.rx_parity_err, 0);
        check("rst_ferr_a", ifa.rx_frame_err, 0);
        check("rst_busy_a", ifa.rx_busy, 0);
        check("rst_ovr_a", ifa.rx_overrun, 0);
        check("rst_valid_b", ifb.rx_valid, 0);
        check("rst_busy_c", ifc.rx_busy, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);

        // 8N1 0xA5: valid one cycle after the stop sample (3 sync/detect + 8 + 9*16).
        ifa.rx_ready = 1'b1;
        q_a.push_back({2'b00, 8'hA5});
        send_frame(0, 8'hA5, 8, 0, 1'b0, 2'b11, 1, t0);
        idle(20);
        check("t1_valid_latency", rise_a - t0, 155);
        check("t1_busy_after", ifa.rx_busy, 0);
        check("t1_drained", q_a.size(), 0);

        // 7E2: 0x2B has even parity bit 0; send 1, then a frame with a low second stop.
        ifb.rx_ready = 1'b1;
        q_b.push_back({1'b0, 1'b1, 8'h2B});
        send_frame(1, 8'h2B, 7, 2, 1'b1, 2'b11, 2, t0);
        idle(20);
        q_b.push_back({1'b1, 1'b0, 8'h2B});
        send_frame(1, 8'h2B, 7, 2, 1'b0, 2'b01, 2, t0);
        idle(20);
        check("t2_drained", q_b.size(), 0);
        check("t2_busy_after", ifb.rx_busy, 0);

        // 4-cycle glitch: false start, busy pulses, nothing pushed.
        busy_seen_a = 1'b0;
        valid_seen_a = 1'b0;
        @(posedge clk);
        #1 rx_a = 1'b0;
        repeat (4) @(posedge clk);
        #1 rx_a = 1'b1;
        idle(40);
        check("t3_busy_pulsed", busy_seen_a, 1);
        check("t3_no_push", valid_seen_a, 0);
        check("t3_busy_after", ifa.rx_busy, 0);

        // Depth 2, no pops: third frame overruns once.
        o0 = ovr_c;
        q_c.push_back({2'b00, 8'h11});
        q_c.push_back({2'b00, 8'h22});
        send_frame(2, 8'h11, 8, 0, 1'b0, 2'b11, 1, t0);
        send_frame(2, 8'h22, 8, 0, 1'b0, 2'b11, 1, t0);
        send_frame(2, 8'h33, 8, 0, 1'b0, 2'b11, 1, t0);
        idle(20);
        check("t4_overrun_pulses", ovr_c - o0, 1);
        check("t4_valid_full", ifc.rx_valid, 1);
        check("t4_head_stable", ifc.rx_data, 8'h11);
        @(posedge clk);
        #1 ifc.rx_ready = 1'b1;
        idle(10);
        check("t4_valid_drained", ifc.rx_valid, 0);
        check("t4_queue_drained", q_c.size(), 0);

        // Full FIFO popped on exactly the cycle the next frame completes.
        ifc.rx_ready = 1'b0;
        o0 = ovr_c;
        q_c.push_back({2'b00, 8'h44});
        q_c.push_back({2'b00, 8'h55});
        q_c.push_back({2'b00, 8'h66});
        send_frame(2, 8'h44, 8, 0, 1'b0, 2'b11, 1, t0);
        send_frame(2, 8'h55, 8, 0, 1'b0, 2'b11, 1, t0);
        fork
            send_frame(2, 8'h66, 8, 0, 1'b0, 2'b11, 1, t0);
            begin
                @(posedge clk);
                repeat (154) @(posedge clk);
                #1 ifc.rx_ready = 1'b1;
                @(posedge clk);
                #1 ifc.rx_ready = 1'b0;
            end
        join
        idle(20);
        check("t5_no_overrun", ovr_c - o0, 0);
        check("t5_two_left", q_c.size(), 2);
        @(posedge clk);
        #1 ifc.rx_ready = 1'b1;
        idle(10);
        check("t5_drained", q_c.size(), 0);
        check("t5_valid_after", ifc.rx_valid, 0);

        // Reset in the middle of data bit 3, then a clean 0x5A.
        valid_seen_a = 1'b0;
        @(posedge clk);
        #1;
        hold_bit(0, 1'b0);
        hold_bit(0, 1'b1);
        hold_bit(0, 1'b1);
        hold_bit(0, 1'b0);
        drive(0, 1'b0);
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("t6_rst_busy", ifa.rx_busy, 0);
        check("t6_rst_valid", ifa.rx_valid, 0);
        rx_a = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(20);
        check("t6_no_residue", valid_seen_a, 0);
        q_a.push_back({2'b00, 8'h5A});
        send_frame(0, 8'h5A, 8, 0, 1'b0, 2'b11, 1, t0);
        idle(20);
        check("t6_one_entry", q_a.size(), 0);
        check("t6_valid_after", ifa.rx_valid, 0);
        check("t6_no_overrun", ovr_a, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver: the next generation of the CPU's serial input path. Adds configurable data width, optional parity, 1 or 2 stop bits, a metastability synchroniser, false-start rejection, per-frame error flags and a small receive FIFO with a valid/ready pop interface. It sits between the external `rx` pin and the CPU/IO bus register block, which drains received bytes at its own pace.

## Interface
- `DATA_BITS`, 8: data bits per frame, legal values 5..8.
- `PARITY`, 0: parity mode. 0 none, 1 odd, 2 even.
- `STOP_BITS`, 1: stop bits checked, 1 or 2.
- `DIV_RATE`, 16: clocks per bit period, at least 4.
- `FIFO_DEPTH`, 4: receive FIFO entries, a power of 2 and at least 2.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous assert, active-high (`RstEnable`).
- `rx`  in  1  serial line, asynchronous to `clk`, idles high.
- `rx_data`  out  DATA_BITS  FIFO head data, LSB is the first bit received.
- `rx_parity_err`  out  1  FIFO head frame failed its parity check.
- `rx_frame_err`  out  1  FIFO head frame had a low stop bit.
- `rx_valid`  out  1  FIFO is not empty.
- `rx_ready`  in  1  consumer pops the head when `rx_valid && rx_ready`.
- `rx_busy`  out  1  receive FSM is not IDLE.
- `rx_overrun`  out  1  one-cycle pulse when a completed frame is dropped because the FIFO is full.

## Operation
- `rx` passes through a 2-flop synchroniser; the synchroniser resets to 1. All logic below uses the synchronised signal `rxs`.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE → START when `rxs == 0`. `div_cnt` loads `DIV_RATE/2 - 1`.
- START: at `div_cnt == 0`, sample `rxs`.
  - If low, go to DATA.
  - If high, this is a false start; return to IDLE with no error flagged.
- Every non-IDLE state reloads `div_cnt` with `DIV_RATE - 1` on each sample, so every sample lands at the middle of its bit.
- DATA: shift right into `shreg`, LSB first, for `DATA_BITS` samples. `bit_cnt` is a 3-bit counter and wraps at `DATA_BITS - 1`. When done, go to PARITY if `PARITY != 0`, otherwise go to STOP.
- PARITY: sample the bit and compare it with the expected value. Expected value is `^shreg` for even parity and `~^shreg` for odd parity. Any mismatch sets `perr`.
- STOP: take `STOP_BITS` samples. Any low sample sets `ferr`. On the final stop sample:
  - Push `{ferr, perr, shreg}` into the FIFO.
  - Clear `perr` and `ferr`.
  - Go to IDLE in the same cycle. This allows back-to-back frames with no idle gap.
- FIFO push when full: the frame is discarded, `rx_overrun` pulses for 1 cycle, and FIFO contents are unchanged.
  - Exception: a push and a pop in the same cycle on a full FIFO are both accepted, and no overrun is raised.
- Push and pop in the same cycle on a non-empty FIFO: the count is unchanged.
- No pop can occur on an empty FIFO, because `rx_valid` is 0.
- Break condition (line held low) is reported as a frame with data 0 and `rx_frame_err` = 1, followed by IDLE. The FSM does not re-arm until `rxs` goes high and then low again.
- Reset (asynchronous, any time, including mid-frame):
  - FSM returns to IDLE, counters clear, FIFO empties.
  - Outputs: `rx_valid` = 0, `rx_data` = 0, `rx_parity_err` = 0, `rx_frame_err` = 0, `rx_busy` = 0, `rx_overrun` = 0.
  - A partial frame is lost silently.

## Timing
- Input latency: 2 `clk` cycles from the `rx` pin to `rxs`.
- Start-edge detection takes 1 more cycle. The start sample falls `DIV_RATE/2` cycles later.
- Bit n (n = 0 for the first data bit) is sampled at `DIV_RATE/2 + (n+1)*DIV_RATE` cycles after start detection.
- `rx_valid` rises 1 cycle after the final stop sample.
- Head outputs are registered FIFO read data. They change the cycle after a pop and are stable while `rx_valid && !rx_ready`.
- `rx_busy` is high from the cycle after start detection until the cycle after the final stop sample.
- Baud tolerance: ±4% at `DIV_RATE` = 16.

## Structure
- Shared constants go in `defines.v`:
  - `UART_PARITY_NONE`, `UART_PARITY_ODD`, `UART_PARITY_EVEN`
  - receive state encodings
  - `UART_START_BIT` and `UART_STOP_BIT`
- Counter widths are derived locally with `$clog2`.
- One sub-module, `uart_rx_fifo`: a synchronous FIFO parametrised by width (`DATA_BITS + 2`) and depth, with a full/empty flag pair and a pointer-plus-extra-bit occupancy scheme.

## Test plan
- 8N1, `DIV_RATE` = 16. Send 0xA5. Expect `rx_valid` 1 cycle after the stop sample, `rx_data` = 0xA5, both error flags 0, `rx_busy` low afterwards.
- 7E2. Send 0x2B with the parity bit forced to 1 (correct value is 0). Expect `rx_data` = 0x2B and `rx_parity_err` = 1. Then send 0x2B with the second stop bit low. Expect `rx_frame_err` = 1.
- Drive a 4-cycle low glitch on an idle line. Expect `rx_busy` to pulse, no FIFO push, and `rx_valid` to stay 0.
- `FIFO_DEPTH` = 2, `rx_ready` = 0. Send 0x11, 0x22, 0x33 back to back. Expect a single `rx_overrun` pulse at the third frame, then pops return 0x11 and 0x22, then `rx_valid` = 0.
- Full FIFO with `rx_ready` = 1 on the cycle the next frame completes. Expect the frame accepted, no overrun, and FIFO order preserved.
- Assert `rst` mid-way through data bit 3, then release it and send 0x5A. Expect no residue from the partial frame and exactly one entry, 0x5A.
